// File: rtl/speed_pkg.sv
// speed_pkg: shared types and constants for the wheel-speed gate controller
// and the pulse counter it drives (state codes, BCD limits, default timing).
package speed_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_GATE   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_LATCH  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    CLEAR  = ST_CLEAR,
    GATE   = ST_GATE,
    SETTLE = ST_SETTLE,
    LATCH  = ST_LATCH
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int DEF_TW            = 26;
  localparam int DEF_GATE_CYCLES   = 50_000_000;
  localparam int DEF_CLR_CYCLES    = 8;
  localparam int DEF_SETTLE_CYCLES = 8;

  typedef struct packed {
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd3_t;

  function automatic logic bcd_ovf(bcd3_t v);
    return (v.d2 > BCD_MAX) ||
           (v.d1 > BCD_MAX) ||
           (v.d0 > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_sat_latch.sv
// bcd_sat_latch: captures three BCD digits on load, saturating to 999 on overflow.
// Ports: clk, reset (async high), load, cnt (in digits), spd (held digits), spd_valid, spd_ovf.
module bcd_sat_latch
  import speed_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  bcd3_t cnt,
  output bcd3_t spd,
  output logic  spd_valid,
  output logic  spd_ovf
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spd       <= '0;
      spd_valid <= 1'b0;
      spd_ovf   <= 1'b0;
    end else begin
      spd_valid <= load;
      if (load) begin
        if (bcd_ovf(cnt)) begin
          spd     <= {BCD_MAX, BCD_MAX, BCD_MAX};
          spd_ovf <= 1'b1;
        end else begin
          spd     <= cnt;
          spd_ovf <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/speed_gate_ctrl.sv
// speed_gate_ctrl: clear/gate/settle sequencer for the wheel-speed pulse counter.
// Ports: clk, reset (async high), en, gate, clr_count, cnt0..2 (in), spd0..2, spd_valid, spd_ovf, busy.
module speed_gate_ctrl
  import speed_pkg::*;
#(
  parameter int TW            = DEF_TW,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       gate,
  output logic       clr_count,
  input  logic [3:0] cnt0,
  input  logic [3:0] cnt1,
  input  logic [3:0] cnt2,
  output logic [3:0] spd0,
  output logic [3:0] spd1,
  output logic [3:0] spd2,
  output logic       spd_valid,
  output logic       spd_ovf,
  output logic       busy
);

  localparam logic [TW-1:0] CLR_TC = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] GATE_TC = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] SET_TC = TW'(SETTLE_CYCLES - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          load;
  bcd3_t         cnt_in;
  bcd3_t         spd_q;

  // Digits are captured on the edge that ends SETTLE, so the
  // held values and spd_valid appear together in the LATCH cycle.
  assign load = (state == SETTLE) && (timer == SET_TC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      gate      <= 1'b0;
      clr_count <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (en) begin
            state     <= CLEAR;
            clr_count <= 1'b1;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          if (timer == CLR_TC) begin
            state     <= GATE;
            timer     <= '0;
            clr_count <= 1'b0;
            gate      <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GATE: begin
          if (timer == GATE_TC) begin
            state <= SETTLE;
            timer <= '0;
            gate  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SETTLE: begin
          if (timer == SET_TC) begin
            state <= LATCH;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LATCH: begin
          timer <= '0;
          if (en) begin
            state     <= CLEAR;
            clr_count <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          timer     <= '0;
          gate      <= 1'b0;
          clr_count <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_in = {cnt2, cnt1, cnt0};

  bcd_sat_latch u_latch (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .cnt       (cnt_in),
    .spd       (spd_q),
    .spd_valid (spd_valid),
    .spd_ovf   (spd_ovf)
  );

  assign spd2 = spd_q.d2;
  assign spd1 = spd_q.d1;
  assign spd0 = spd_q.d0;

endmodule

// File: tb/tb_speed_gate_ctrl.sv
// tb_speed_gate_ctrl: randomized bench for speed_gate_ctrl against a
// position-in-period reference model.
module tb_speed_gate_ctrl;

  localparam int G   = 20;
  localparam int C   = 2;
  localparam int S   = 3;
  localparam int PER = C + G + S + 1;

  logic       clk;
  logic       reset;
  logic       en;
  logic       gate;
  logic       clr_count;
  logic [3:0] cnt0, cnt1, cnt2;
  logic [3:0] spd0, spd1, spd2;
  logic       spd_valid;
  logic       spd_ovf;
  logic       busy;

  speed_gate_ctrl #(
    .TW            (8),
    .GATE_CYCLES   (G),
    .CLR_CYCLES    (C),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .gate      (gate),
    .clr_count (clr_count),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .spd0      (spd0),
    .spd1      (spd1),
    .spd2      (spd2),
    .spd_valid (spd_valid),
    .spd_ovf   (spd_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: pos = cycle index within a measurement, -1 when idle
  int         pos;
  logic [3:0] m_d2, m_d1, m_d0;
  logic       m_ovf;
  bit         rnd;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos   = -1;
    m_d2  = 4'd0;
    m_d1  = 4'd0;
    m_d0  = 4'd0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      if (pos == PER - 2) begin
        if (cnt2 > 9 || cnt1 > 9 || cnt0 > 9) begin
          {m_d2, m_d1, m_d0} = 12'h999;
          m_ovf = 1'b1;
        end else begin
          {m_d2, m_d1, m_d0} = {cnt2, cnt1, cnt0};
          m_ovf = 1'b0;
        end
      end
      if (pos < 0 || pos == PER - 1) pos = en ? 0 : -1;
      else pos++;
    end
  endtask

  task automatic check_outs();
    chk("clr_count", clr_count, pos >= 0 && pos < C);
    chk("gate", gate, pos >= C && pos < C + G);
    chk("busy", busy, pos >= 0);
    chk("spd_valid", spd_valid, pos == PER - 1);
    chk("spd_ovf", spd_ovf, m_ovf);
    chk("spd", {spd2, spd1, spd0}, {m_d2, m_d1, m_d0});
    chk("excl", gate & clr_count, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
    if (rnd) begin
      cnt0 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                         : 4'($urandom_range(0, 9));
      cnt1 = 4'($urandom_range(0, 9));
      cnt2 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15))
                                         : 4'($urandom_range(0, 9));
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(int p);
    for (int i = 0; i < 4 * PER && pos != p; i++) step();
    if (pos != p) chk("run_to_timeout", pos, p);
  endtask

  initial begin
    rnd   = 1'b0;
    reset = 1'b1;
    en    = 1'b0;
    cnt0  = 4'd0;
    cnt1  = 4'd0;
    cnt2  = 4'd0;
    model_reset();
    #2;
    check_outs();
    run(2);
    reset = 1'b0;
    run(3);

    // first window: digits 1/2/3
    en = 1'b1;
    {cnt2, cnt1, cnt0} = 12'h123;
    run(PER + 1);
    run_to(PER - 1);
    chk("spd_123", {spd2, spd1, spd0}, 12'h123);

    // overflow then recovery
    {cnt2, cnt1, cnt0} = {4'd12, 4'd3, 4'd4};
    run(PER);
    chk("spd_sat", {spd2, spd1, spd0}, 12'h999);
    chk("ovf_set", spd_ovf, 1'b1);
    {cnt2, cnt1, cnt0} = 12'h045;
    run(PER);
    chk("spd_045", {spd2, spd1, spd0}, 12'h045);
    chk("ovf_clr", spd_ovf, 1'b0);

    // drop en mid-gate
    run_to(C + 10);
    en = 1'b0;
    run(PER + 10);
    chk("idle_busy", busy, 1'b0);

    // async reset mid-gate
    en = 1'b1;
    {cnt2, cnt1, cnt0} = 12'h777;
    run(1);
    run_to(C + 5);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outs();
    step();
    reset = 1'b0;
    run(PER + 2);

    // random digits every cycle with occasional en toggles
    rnd = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      step();
    end
    en = 1'b1;
    run(3 * PER);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
